// File: rtl/uop_queue_if.sv
// uop_queue_if: bundles the decode-side enqueue bus, the backend-side
// dequeue bus and the queue status signals of uop_queue.
//   slave  : the queue itself (takes enq_*, deq_stall, flush; drives the rest)
//   master : decode/backend side (drives enq_*, deq_stall, flush)
// Enqueue : enq_valid, enq_ready, enq_uop, enq_eoi, enq_imm, enq_use_imm,
//           enq_pc, enq_except, enq_src1_arch, enq_src2_arch, enq_dest_arch
// Dequeue : deq_stall, uop_ready, uop, eoi, imm, use_imm, pc, except,
//           src1_arch, src2_arch, dest_arch
// Control : flush
// Status  : count, empty, full
interface uop_queue_if #(
    parameter int NUM_UOPS      = 32,
    parameter int XLEN          = 32,
    parameter int ARCHFILE_SIZE = 32,
    parameter int DEPTH         = 8
);
    localparam int UOP_W = $clog2(NUM_UOPS);
    localparam int REG_W = $clog2(ARCHFILE_SIZE);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             enq_valid;
    logic             enq_ready;
    logic [UOP_W-1:0] enq_uop;
    logic             enq_eoi;
    logic [XLEN-1:0]  enq_imm;
    logic             enq_use_imm;
    logic [31:0]      enq_pc;
    logic             enq_except;
    logic [REG_W-1:0] enq_src1_arch;
    logic [REG_W-1:0] enq_src2_arch;
    logic [REG_W-1:0] enq_dest_arch;

    logic             deq_stall;
    logic             flush;

    logic             uop_ready;
    logic [UOP_W-1:0] uop;
    logic             eoi;
    logic [XLEN-1:0]  imm;
    logic             use_imm;
    logic [31:0]      pc;
    logic             except;
    logic [REG_W-1:0] src1_arch;
    logic [REG_W-1:0] src2_arch;
    logic [REG_W-1:0] dest_arch;

    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;

    modport slave (
        input  enq_valid, enq_uop, enq_eoi, enq_imm, enq_use_imm, enq_pc,
               enq_except, enq_src1_arch, enq_src2_arch, enq_dest_arch,
               deq_stall, flush,
        output enq_ready, uop_ready, uop, eoi, imm, use_imm, pc, except,
               src1_arch, src2_arch, dest_arch, count, empty, full
    );

    modport master (
        output enq_valid, enq_uop, enq_eoi, enq_imm, enq_use_imm, enq_pc,
               enq_except, enq_src1_arch, enq_src2_arch, enq_dest_arch,
               deq_stall, flush,
        input  enq_ready, uop_ready, uop, eoi, imm, use_imm, pc, except,
               src1_arch, src2_arch, dest_arch, count, empty, full
    );
endinterface

// File: rtl/uop_queue.sv
// uop_queue: circular FIFO of decoded micro-ops between decode and the
// backend. First-word fall-through with no bypass: an entry becomes visible
// at the head the cycle after it is written. Head fields are forced to 0
// whenever uop_ready is low. flush clears the queue synchronously.
// Ports:
//   clk : clock
//   rst : asynchronous active-low reset
//   q   : uop_queue_if.slave (enqueue bus, dequeue bus, flush, status)
module uop_queue #(
    parameter int NUM_UOPS      = 32,
    parameter int XLEN          = 32,
    parameter int ARCHFILE_SIZE = 32,
    parameter int DEPTH         = 8
) (
    input  logic        clk,
    input  logic        rst,
    uop_queue_if.slave  q
);
    localparam int UOP_W = $clog2(NUM_UOPS);
    localparam int REG_W = $clog2(ARCHFILE_SIZE);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;

    // Entry storage carries no reset; occupancy is tracked by r_count alone.
    logic [UOP_W-1:0] r_mem_uop    [DEPTH];
    logic             r_mem_eoi    [DEPTH];
    logic [XLEN-1:0]  r_mem_imm    [DEPTH];
    logic             r_mem_use_imm[DEPTH];
    logic [31:0]      r_mem_pc     [DEPTH];
    logic             r_mem_except [DEPTH];
    logic [REG_W-1:0] r_mem_src1   [DEPTH];
    logic [REG_W-1:0] r_mem_src2   [DEPTH];
    logic [REG_W-1:0] r_mem_dest   [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_enq;
    logic w_deq;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_FULL);

    // enq_ready looks only at the occupancy: a full queue refuses even when
    // a dequeue happens in the same cycle, keeping deq_stall/flush off this path.
    assign w_enq = q.enq_valid && !w_full && !q.flush;
    assign w_deq = !w_empty && !q.deq_stall && !q.flush;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_enq, w_deq})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (q.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            // Pointers are exactly PTR_W wide, so DEPTH being a power of two
            // gives the modulo wrap for free.
            if (w_enq) r_tail <= r_tail + 1'b1;
            if (w_deq) r_head <= r_head + 1'b1;
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem_uop[r_tail]     <= q.enq_uop;
            r_mem_eoi[r_tail]     <= q.enq_eoi;
            r_mem_imm[r_tail]     <= q.enq_imm;
            r_mem_use_imm[r_tail] <= q.enq_use_imm;
            r_mem_pc[r_tail]      <= q.enq_pc;
            r_mem_except[r_tail]  <= q.enq_except;
            r_mem_src1[r_tail]    <= q.enq_src1_arch;
            r_mem_src2[r_tail]    <= q.enq_src2_arch;
            r_mem_dest[r_tail]    <= q.enq_dest_arch;
        end
    end

    assign q.enq_ready = !w_full;
    assign q.uop_ready = w_deq;
    assign q.count     = r_count;
    assign q.empty     = w_empty;
    assign q.full      = w_full;

    // Head fields are zeroed unless the head is actually being consumed, so
    // the backend never latches stale or unwritten storage.
    assign q.uop       = w_deq ? r_mem_uop[r_head]     : '0;
    assign q.eoi       = w_deq ? r_mem_eoi[r_head]     : 1'b0;
    assign q.imm       = w_deq ? r_mem_imm[r_head]     : '0;
    assign q.use_imm   = w_deq ? r_mem_use_imm[r_head] : 1'b0;
    assign q.pc        = w_deq ? r_mem_pc[r_head]      : '0;
    assign q.except    = w_deq ? r_mem_except[r_head]  : 1'b0;
    assign q.src1_arch = w_deq ? r_mem_src1[r_head]    : '0;
    assign q.src2_arch = w_deq ? r_mem_src2[r_head]    : '0;
    assign q.dest_arch = w_deq ? r_mem_dest[r_head]    : '0;
endmodule

// File: tb/tb_uop_queue.sv
module tb_uop_queue;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    uop_queue_if #(.NUM_UOPS(32), .XLEN(32), .ARCHFILE_SIZE(32), .DEPTH(8)) q_if ();

    uop_queue #(.NUM_UOPS(32), .XLEN(32), .ARCHFILE_SIZE(32), .DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .q   (q_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one uop on the enqueue bus; fields are derived from pc so that
    // uop == pc[6:2] can be checked at the head.
    task automatic set_enq(input logic [31:0] p);
        q_if.enq_valid     = 1'b1;
        q_if.enq_pc        = p;
        q_if.enq_uop       = p[6:2];
        q_if.enq_imm       = ~p;
        q_if.enq_use_imm   = p[2];
        q_if.enq_eoi       = p[3];
        q_if.enq_except    = p[4];
        q_if.enq_src1_arch = p[6:2];
        q_if.enq_src2_arch = p[7:3];
        q_if.enq_dest_arch = p[8:4];
    endtask

    task automatic test_reset();
        rst = 1'b0;
        q_if.enq_valid = 0; q_if.enq_uop = 0; q_if.enq_eoi = 0; q_if.enq_imm = 0;
        q_if.enq_use_imm = 0; q_if.enq_pc = 0; q_if.enq_except = 0;
        q_if.enq_src1_arch = 0; q_if.enq_src2_arch = 0; q_if.enq_dest_arch = 0;
        q_if.deq_stall = 0; q_if.flush = 0;
        step(); step();
        total++; if (q_if.count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", q_if.count); end
        total++; if (q_if.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", q_if.empty); end
        total++; if (q_if.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", q_if.full); end
        total++; if (q_if.enq_ready !== 1'b1) begin bad++; $display("FAIL reset_enq_ready got=%b exp=1", q_if.enq_ready); end
        total++; if (q_if.uop_ready !== 1'b0) begin bad++; $display("FAIL reset_uop_ready got=%b exp=0", q_if.uop_ready); end
        total++; if (q_if.pc !== 32'h0 || q_if.imm !== 32'h0) begin bad++; $display("FAIL reset_fields pc=%h imm=%h exp=0", q_if.pc, q_if.imm); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        q_if.enq_valid = 1; q_if.enq_uop = 5'h0A; q_if.enq_pc = 32'h1000;
        q_if.enq_imm = 32'hFFFF_FFFC; q_if.enq_use_imm = 1; q_if.enq_dest_arch = 5'd3;
        q_if.enq_eoi = 1; q_if.enq_except = 0; q_if.enq_src1_arch = 5'd1; q_if.enq_src2_arch = 5'd2;
        #1;
        total++; if (q_if.uop_ready !== 1'b0) begin bad++; $display("FAIL basic_no_bypass got=%b exp=0", q_if.uop_ready); end
        step();
        q_if.enq_valid = 0;
        #1;
        total++; if (q_if.uop_ready !== 1'b1) begin bad++; $display("FAIL basic_uop_ready got=%b exp=1", q_if.uop_ready); end
        total++; if (q_if.uop !== 5'h0A || q_if.pc !== 32'h1000 || q_if.imm !== 32'hFFFF_FFFC)
            begin bad++; $display("FAIL basic_fields uop=%h pc=%h imm=%h exp=0a/1000/fffffffc", q_if.uop, q_if.pc, q_if.imm); end
        total++; if (q_if.use_imm !== 1'b1 || q_if.dest_arch !== 5'd3 || q_if.eoi !== 1'b1 || q_if.except !== 1'b0)
            begin bad++; $display("FAIL basic_flags use_imm=%b dest=%0d eoi=%b exc=%b exp=1/3/1/0", q_if.use_imm, q_if.dest_arch, q_if.eoi, q_if.except); end
        total++; if (q_if.src1_arch !== 5'd1 || q_if.src2_arch !== 5'd2)
            begin bad++; $display("FAIL basic_srcs s1=%0d s2=%0d exp=1/2", q_if.src1_arch, q_if.src2_arch); end
        step();
        total++; if (q_if.empty !== 1'b1 || q_if.uop_ready !== 1'b0)
            begin bad++; $display("FAIL basic_drained empty=%b uop_ready=%b exp=1/0", q_if.empty, q_if.uop_ready); end
    endtask

    task automatic test_fill_stall();
        q_if.deq_stall = 1;
        for (int i = 0; i < 9; i++) begin
            set_enq(32'(4 * i));
            #1;
            if (i == 8) begin
                total++; if (q_if.full !== 1'b1 || q_if.enq_ready !== 1'b0)
                    begin bad++; $display("FAIL fill_full full=%b enq_ready=%b exp=1/0", q_if.full, q_if.enq_ready); end
            end
            step();
        end
        q_if.enq_valid = 0;
        #1;
        total++; if (q_if.count !== 4'd8) begin bad++; $display("FAIL fill_count got=%0d exp=8", q_if.count); end
        total++; if (q_if.uop_ready !== 1'b0) begin bad++; $display("FAIL fill_stalled got=%b exp=0", q_if.uop_ready); end
        total++; if (q_if.pc !== 32'h0 || q_if.uop !== 5'h0 || q_if.imm !== 32'h0)
            begin bad++; $display("FAIL fill_gated pc=%h uop=%h imm=%h exp=0", q_if.pc, q_if.uop, q_if.imm); end
    endtask

    task automatic test_drain_wrap();
        int exp_q[$];
        int sent;
        int cyc;
        bit exp_rdy;
        bit acc;
        logic [31:0] npc;
        for (int i = 0; i < 8; i++) exp_q.push_back(4 * i);
        sent = 0;
        cyc = 0;
        q_if.deq_stall = 0;
        while ((exp_q.size() > 0 || sent < 16) && cyc < 100) begin
            npc = 32'h100 + 32'(4 * sent);
            if (sent < 16) set_enq(npc);
            else q_if.enq_valid = 0;
            #1;
            exp_rdy = (exp_q.size() > 0);
            total++; if (q_if.count !== 4'(exp_q.size()))
                begin bad++; $display("FAIL drain_count cyc=%0d got=%0d exp=%0d", cyc, q_if.count, exp_q.size()); end
            total++; if (q_if.enq_ready !== (exp_q.size() < 8))
                begin bad++; $display("FAIL drain_enq_ready cyc=%0d got=%b exp=%b", cyc, q_if.enq_ready, exp_q.size() < 8); end
            total++; if (q_if.uop_ready !== exp_rdy)
                begin bad++; $display("FAIL drain_uop_ready cyc=%0d got=%b exp=%b", cyc, q_if.uop_ready, exp_rdy); end
            if (exp_rdy) begin
                total++; if (q_if.pc !== 32'(exp_q[0]) || q_if.uop !== 5'((exp_q[0] >> 2) & 31))
                    begin bad++; $display("FAIL drain_order cyc=%0d pc=%h uop=%h exp_pc=%h", cyc, q_if.pc, q_if.uop, exp_q[0]); end
            end
            acc = (sent < 16) && (exp_q.size() < 8);
            step();
            if (exp_rdy) void'(exp_q.pop_front());
            if (acc) begin exp_q.push_back(int'(npc)); sent++; end
            cyc++;
        end
        q_if.enq_valid = 0;
        total++; if (cyc >= 100) begin bad++; $display("FAIL drain_timeout cyc=%0d limit=100", cyc); end
        #1;
        total++; if (q_if.empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", q_if.empty); end
    endtask

    task automatic test_simultaneous();
        int exp_q[$];
        logic [31:0] npc;
        q_if.deq_stall = 1;
        for (int i = 0; i < 4; i++) begin
            set_enq(32'h200 + 32'(4 * i));
            exp_q.push_back(32'h200 + 4 * i);
            step();
        end
        q_if.deq_stall = 0;
        for (int k = 0; k < 10; k++) begin
            npc = 32'h300 + 32'(4 * k);
            set_enq(npc);
            #1;
            total++; if (q_if.count !== 4'd4 || q_if.uop_ready !== 1'b1)
                begin bad++; $display("FAIL simul_steady k=%0d count=%0d uop_ready=%b exp=4/1", k, q_if.count, q_if.uop_ready); end
            total++; if (q_if.pc !== 32'(exp_q[0]))
                begin bad++; $display("FAIL simul_order k=%0d pc=%h exp=%h", k, q_if.pc, exp_q[0]); end
            step();
            void'(exp_q.pop_front());
            exp_q.push_back(int'(npc));
        end
    endtask

    task automatic test_flush();
        q_if.deq_stall = 1;
        set_enq(32'h400);
        step();
        q_if.enq_valid = 0;
        #1;
        total++; if (q_if.count !== 4'd5) begin bad++; $display("FAIL flush_pre_count got=%0d exp=5", q_if.count); end
        q_if.deq_stall = 0;
        q_if.flush = 1;
        set_enq(32'hDEAD0);
        #1;
        total++; if (q_if.uop_ready !== 1'b0 || q_if.pc !== 32'h0)
            begin bad++; $display("FAIL flush_cycle uop_ready=%b pc=%h exp=0/0", q_if.uop_ready, q_if.pc); end
        step();
        q_if.flush = 0;
        q_if.enq_valid = 0;
        #1;
        total++; if (q_if.count !== 4'd0 || q_if.empty !== 1'b1)
            begin bad++; $display("FAIL flush_cleared count=%0d empty=%b exp=0/1", q_if.count, q_if.empty); end
        total++; if (q_if.uop_ready !== 1'b0) begin bad++; $display("FAIL flush_dropped uop_ready=%b exp=0", q_if.uop_ready); end
        step();
        total++; if (q_if.uop_ready !== 1'b0 || q_if.count !== 4'd0)
            begin bad++; $display("FAIL flush_stays_empty uop_ready=%b count=%0d exp=0/0", q_if.uop_ready, q_if.count); end
    endtask

    task automatic test_async_reset();
        q_if.deq_stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_enq(32'h500 + 32'(4 * i));
            step();
        end
        q_if.enq_valid = 0;
        q_if.deq_stall = 0;
        #1;
        total++; if (q_if.count !== 4'd3 || q_if.uop_ready !== 1'b1 || q_if.pc !== 32'h500)
            begin bad++; $display("FAIL arst_pre count=%0d uop_ready=%b pc=%h exp=3/1/500", q_if.count, q_if.uop_ready, q_if.pc); end
        #2;
        rst = 1'b0;
        #1;
        total++; if (q_if.count !== 4'd0 || q_if.empty !== 1'b1)
            begin bad++; $display("FAIL arst_count count=%0d empty=%b exp=0/1", q_if.count, q_if.empty); end
        total++; if (q_if.uop_ready !== 1'b0 || q_if.pc !== 32'h0 || q_if.imm !== 32'h0)
            begin bad++; $display("FAIL arst_outputs uop_ready=%b pc=%h imm=%h exp=0", q_if.uop_ready, q_if.pc, q_if.imm); end
        step();
        rst = 1'b1;
        step();
        total++; if (q_if.empty !== 1'b1 || q_if.uop_ready !== 1'b0)
            begin bad++; $display("FAIL arst_restart empty=%b uop_ready=%b exp=1/0", q_if.empty, q_if.uop_ready); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_basic();
        test_fill_stall();
        test_drain_wrap();
        test_simultaneous();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uop_queue.md
Name: uop_queue

Overview:
- Circular FIFO of decoded micro-ops between decode/uop-generation and the backend (mapper + regfile read).
- Buffers one uop per cycle from decode and presents the head uop to the backend with a single-cycle valid pulse per uop (uop_ready).
- Absorbs backend back-pressure (ROB full, mapper stall) and supports a full flush on pipeline redirect.

Parameters:
- NUM_UOPS, 32, number of uop encodings; uop field width is $clog2(NUM_UOPS).
- XLEN, 32, immediate width.
- ARCHFILE_SIZE, 32, architectural register count; register index width is $clog2(ARCHFILE_SIZE).
- DEPTH, 8, number of queue entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- enq_valid  in  1  decode presents a uop this cycle
- enq_ready  out  1  queue can accept; equals (count < DEPTH)
- enq_uop  in  $clog2(NUM_UOPS)  uop encoding
- enq_eoi  in  1  last uop of its instruction
- enq_imm  in  XLEN  immediate
- enq_use_imm  in  1  op2 comes from the immediate
- enq_pc  in  32  instruction PC
- enq_except  in  1  decode-detected exception
- enq_src1_arch, enq_src2_arch, enq_dest_arch  in  $clog2(ARCHFILE_SIZE) each  architectural register indices
- deq_stall  in  1  backend cannot accept this cycle (ROB full / mapper stall)
- flush  in  1  synchronous flush of all entries
- uop_ready  out  1  head uop is valid and is consumed this cycle
- uop, eoi, imm, use_imm, pc, except, src1_arch, src2_arch, dest_arch  out  widths as the matching enq_* ports  head entry fields
- count  out  $clog2(DEPTH)+1  number of occupied entries
- empty  out  1  count == 0
- full  out  1  count == DEPTH

Behaviour:
- Reset (rst=0, asynchronous): head_ptr, tail_ptr and count are 0, so empty=1, full=0, enq_ready=1 and uop_ready=0. All head-field outputs are 0. Entry storage does not need a reset.
- Reset deasserting mid-operation: the queue restarts empty. Uops enqueued before reset are lost.
- Enqueue:
  - Occurs when enq_valid && enq_ready && !flush at a rising edge.
  - Writes the entry at tail_ptr, then tail_ptr increments modulo DEPTH (natural wrap).
- enq_ready depends only on count. There is no combinational path from deq_stall or flush to enq_ready. When full, an enqueue is refused even if a dequeue happens in the same cycle.
- Dequeue:
  - uop_ready = !empty && !deq_stall && !flush (combinational).
  - When uop_ready=1 at an edge, head_ptr increments modulo DEPTH.
  - This is first-word fall-through: head fields are read combinationally from entry[head_ptr].
- Output gating: when uop_ready=0, all head-field outputs are driven to 0, so the backend never sees stale data.
- Count update:
  - +1 on enqueue only.
  - -1 on dequeue only.
  - Unchanged when both or neither occur.
- No bypass: a uop enqueued into an empty queue appears at the outputs in the following cycle (1-cycle minimum latency).
- Flush:
  - At the edge where flush=1, head_ptr, tail_ptr and count are cleared to 0.
  - Any same-cycle enqueue is dropped and uop_ready is forced to 0.
  - The queue is empty in the next cycle.
- Field integrity: every field, including eoi and except, travels unchanged with its entry. Ordering is strict FIFO.
- Fill level: the queue holds exactly DEPTH entries before it stops accepting. After 2*DEPTH enqueue/dequeue pairs, pointers have wrapped twice with no data corruption.

Test Plan:
- Reset/basic: hold rst=0, then release; enqueue one uop (uop=5'h0A, pc=32'h1000, imm=32'hFFFF_FFFC, use_imm=1, dest_arch=3) with deq_stall=0. Required response: uop_ready=1 exactly one cycle after the enqueue with identical fields, then empty=1.
- Fill and stall: deq_stall=1; enqueue 9 uops with pc=0x0,0x4,...,0x20. Required response: the first 8 are accepted, full=1, enq_ready=0, the 9th is refused (count stays 8), uop_ready=0 and all outputs are 0.
- Drain order and wrap: continuing from the stall test, release deq_stall while streaming 16 new uops at one per cycle. Required response: PCs emerge in strict order 0x0..0x1C followed by the new ones, count never exceeds 8, and no entry is duplicated or lost across the pointer wrap.
- Simultaneous enqueue/dequeue: with count=4, assert enq_valid=1 and deq_stall=0 for 10 cycles. Required response: count holds at 4 and uop_ready=1 every cycle.
- Flush: with count=5, assert flush=1 together with enq_valid=1. Required response: in the next cycle count=0, empty=1, and during the flush cycle uop_ready=0. The flush-cycle uop never appears at the outputs.
- Async reset mid-stream: with count=3, pull rst low between clock edges. Required response: count=0, uop_ready=0 and all outputs are 0 immediately, without waiting for a clock edge.
